// File: rtl/mm_result_readout.sv
// mm_result_readout: result store and host readout serializer.
// Stores 18-bit results from the compute core in SLOTS x RESULTS entries.
// A host read streams one slot as 32 nine-bit beats, low half first.
// Optional macro MM_RESULT_CLEAR_EN: clears every storage entry on reset.
module mm_result_readout #(
  parameter int SLOTS   = 32,
  parameter int SLOT_AW = 5,
  parameter int RESULTS = 16,
  parameter int RES_W   = 18,
  parameter int OUT_W   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               res_we,
  input  logic [SLOT_AW-1:0] res_slot,
  input  logic [3:0]         res_idx,
  input  logic [RES_W-1:0]   res_data,
  input  logic               read,
  input  logic [SLOT_AW-1:0] ram_slot,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  output logic               busy
);

  localparam int IDX_W  = 4;
  localparam int ADDR_W = SLOT_AW + IDX_W;
  localparam int DEPTH  = SLOTS * RESULTS;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Flat storage addressed as {slot, entry}
  logic [RES_W-1:0] mem [DEPTH];

  state_t             state_reg, state_next;
  logic [4:0]         beat_reg, beat_next;
  logic [SLOT_AW-1:0] cur_slot_reg, cur_slot_next;
  logic               out_valid_reg, out_valid_next;
  logic               rd_hi_reg, rd_hi_next;
  logic [ADDR_W-1:0]  rd_addr;
  logic [RES_W-1:0]   rd_word_reg;
  logic               start;

`ifdef MM_RESULT_CLEAR_EN
  // Core write port; whole array is zeroed while reset is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (res_we) begin
      mem[{res_slot, res_idx}] <= res_data;
    end
  end
`else
  // Core write port; no reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (res_we) begin
      mem[{res_slot, res_idx}] <= res_data;
    end
  end
`endif

  // Registered read port; read-before-write so a same-edge write is not seen
  always_ff @(posedge clk) begin
    rd_word_reg <= mem[rd_addr];
  end

  // State, beat counter and stream control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      beat_reg      <= '0;
      cur_slot_reg  <= '0;
      out_valid_reg <= 1'b0;
      rd_hi_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      cur_slot_reg  <= cur_slot_next;
      out_valid_reg <= out_valid_next;
      rd_hi_reg     <= rd_hi_next;
    end
  end

  // Next-state logic: a request is taken in IDLE or on the final beat
  // edge, so back-to-back streams keep out_valid continuously high.
  always_comb begin
    state_next     = state_reg;
    beat_next      = beat_reg;
    cur_slot_next  = cur_slot_reg;
    out_valid_next = 1'b0;
    rd_hi_next     = 1'b0;
    rd_addr        = {cur_slot_reg, beat_reg[4:1]};
    start          = read && ((state_reg == IDLE) ||
                              (state_reg == STREAM && beat_reg == 5'd31));
    if (start) begin
      state_next     = STREAM;
      cur_slot_next  = ram_slot;
      beat_next      = 5'd0;
      rd_addr        = {ram_slot, 4'd0};
      rd_hi_next     = 1'b0;
      out_valid_next = 1'b1;
    end else if (state_reg == STREAM) begin
      if (beat_reg != 5'd31) begin
        beat_next      = beat_reg + 5'd1;
        rd_addr        = {cur_slot_reg, beat_next[4:1]};
        rd_hi_next     = beat_next[0];
        out_valid_next = 1'b1;
      end else begin
        state_next = IDLE;
        beat_next  = 5'd0;
      end
    end
  end

  // Half select after the RAM; gated by valid so reset forces zero at once
  assign out_data  = !out_valid_reg ? '0 :
                     (rd_hi_reg ? rd_word_reg[RES_W-1:OUT_W] : rd_word_reg[OUT_W-1:0]);
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg == STREAM);

endmodule

// File: tb/tb_mm_result_readout.sv
// tb_mm_result_readout: directed sequence with random result data, checked
// against a slot/entry array model of the result store.
// Honours MM_RESULT_CLEAR_EN when the bench is built with it.
module tb_mm_result_readout;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_we;
  logic [4:0]  res_slot;
  logic [3:0]  res_idx;
  logic [17:0] res_data;
  logic        read;
  logic [4:0]  ram_slot;
  logic [8:0]  out_data;
  logic        out_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [17:0] model_mem [32][16];
  logic [8:0]  exp_beat;

  mm_result_readout dut (
    .clk       (clk),
    .rst       (rst),
    .res_we    (res_we),
    .res_slot  (res_slot),
    .res_idx   (res_idx),
    .res_data  (res_data),
    .read      (read),
    .ram_slot  (ram_slot),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat b of a slot: entry b/2, low half for even b, high half for odd b
  function automatic logic [8:0] half(input int slot, input int b);
    logic [17:0] w;
    w = model_mem[slot][b / 2];
    return (b % 2 == 1) ? w[17:9] : w[8:0];
  endfunction

  task automatic write_entry(input int slot, input int idx, input logic [17:0] data);
    @(negedge clk);
    res_we   = 1'b1;
    res_slot = 5'(slot);
    res_idx  = 4'(idx);
    res_data = data;
    @(posedge clk);
    #1;
    res_we = 1'b0;
    model_mem[slot][idx] = data;
  endtask

  task automatic fill_random(input int slot);
    for (int i = 0; i < 16; i++) begin
      write_entry(slot, i, 18'($urandom));
    end
  endtask

  // One stream: optional ignored reads, one in-stream write, mid-stream
  // reset, or a chained request on the last beat (next_slot >= 0).
  task automatic do_stream(input int slot, input bit pre, input int noise_lo,
                           input int noise_hi, input int wr_at, input int wr_idx,
                           input logic [17:0] wr_val, input int abort_at,
                           input int next_slot);
    if (!pre) begin
      @(negedge clk);
      read     = 1'b1;
      ram_slot = 5'(slot);
      exp_beat = half(slot, 0);
      @(posedge clk);
      #1;
      read = 1'b0;
    end
    for (int b = 0; b < 32; b++) begin
      @(negedge clk);
      check($sformatf("s%0d_b%0d_valid", slot, b), 18'(out_valid), 18'd1);
      check($sformatf("s%0d_b%0d_busy", slot, b), 18'(busy), 18'd1);
      check($sformatf("s%0d_b%0d_data", slot, b), 18'(out_data), 18'(exp_beat));
      if (b == abort_at) begin
        rst = 1'b0;
        #1;
        check("rst_async_valid", 18'(out_valid), 18'd0);
        check("rst_async_busy", 18'(busy), 18'd0);
        check("rst_async_data", 18'(out_data), 18'd0);
        @(posedge clk);
        #1;
        check("rst_held_valid", 18'(out_valid), 18'd0);
        check("rst_held_data", 18'(out_data), 18'd0);
`ifdef MM_RESULT_CLEAR_EN
        for (int s = 0; s < 32; s++)
          for (int i = 0; i < 16; i++)
            model_mem[s][i] = 18'd0;
`endif
        @(negedge clk);
        rst = 1'b1;
        $display("stream slot=%0d aborted by reset at beat %0d", slot, b);
        return;
      end
      if (b >= noise_lo && b <= noise_hi) begin
        read     = 1'b1;
        ram_slot = 5'((slot + 5) % 32);
      end
      if (b == wr_at) begin
        res_we   = 1'b1;
        res_slot = 5'(slot);
        res_idx  = 4'(wr_idx);
        res_data = wr_val;
      end
      if (b == 31 && next_slot >= 0) begin
        read     = 1'b1;
        ram_slot = 5'(next_slot);
        exp_beat = half(next_slot, 0);
      end else if (b < 31) begin
        exp_beat = half(slot, b + 1);
      end
      @(posedge clk);
      #1;
      if (res_we) begin
        model_mem[slot][wr_idx] = wr_val;
        res_we = 1'b0;
      end
      read = 1'b0;
    end
    if (next_slot < 0) begin
      @(negedge clk);
      check($sformatf("s%0d_end_valid", slot), 18'(out_valid), 18'd0);
      check($sformatf("s%0d_end_busy", slot), 18'(busy), 18'd0);
      check($sformatf("s%0d_end_data", slot), 18'(out_data), 18'd0);
    end
    $display("stream slot=%0d complete (chained_next=%0d)", slot, next_slot);
  endtask

  initial begin
    logic [17:0] old_val;
    int rs;

    rst      = 1'b0;
    res_we   = 1'b0;
    res_slot = '0;
    res_idx  = '0;
    res_data = '0;
    read     = 1'b0;
    ram_slot = '0;
    for (int s = 0; s < 32; s++)
      for (int i = 0; i < 16; i++)
        model_mem[s][i] = 18'd0;

    // Reset state
    #2;
    check("reset_valid", 18'(out_valid), 18'd0);
    check("reset_busy", 18'(busy), 18'd0);
    check("reset_data", 18'(out_data), 18'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    $display("reset released");

    // Slot 3 known pattern: low half = i, high half = 0x100
    for (int i = 0; i < 16; i++) write_entry(3, i, 18'h20000 + 18'(i));
    do_stream(3, 1'b0, -1, -1, -1, 0, 18'd0, -1, -1);

    // Upper slot bound: slot 31 with all-ones last entry, slot 0 distinct
    fill_random(31);
    write_entry(31, 15, 18'h3FFFF);
    fill_random(0);
    write_entry(0, 15, 18'h0AAAA);
    fill_random(5);
    do_stream(31, 1'b0, -1, -1, -1, 0, 18'd0, -1, -1);

    // Reads to slot 5 during beats 4..20 ignored; request at E32 chains slot 5
    do_stream(0, 1'b0, 4, 20, -1, 0, 18'd0, -1, 5);
    do_stream(5, 1'b1, -1, -1, -1, 0, 18'd0, -1, -1);

    // Collision: write entry 3 at the edge registering beat 6
    fill_random(2);
    old_val = (18'($urandom) | 18'h20000) & ~18'h1;
    write_entry(2, 3, old_val);
    do_stream(2, 1'b0, -1, -1, 5, 3, 18'h00155, -1, -1);

    // Random slots
    for (int r = 0; r < 3; r++) begin
      rs = $urandom_range(8, 30);
      fill_random(rs);
      do_stream(rs, 1'b0, -1, -1, -1, 0, 18'd0, -1, -1);
    end

    // Reset mid-stream at beat 10, then the same slot restarts at beat 0
    do_stream(3, 1'b0, -1, -1, -1, 0, 18'd0, 10, -1);
`ifndef MM_RESULT_CLEAR_EN
    do_stream(3, 1'b0, -1, -1, -1, 0, 18'd0, -1, -1);
`else
    do_stream(3, 1'b0, -1, -1, -1, 0, 18'd0, -1, -1);
    do_stream(7, 1'b0, -1, -1, -1, 0, 18'd0, -1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mm_result_readout.md
Name: mm_result_readout

Overview:
- Result store and host readout serializer for the matrix-multiply top level.
- Accepts 18-bit results from the compute core into 32 slots of 16 entries each.
- On a host read request, streams the 16 results of one slot onto the 9-bit out_data bus as 32 beats: low half, then high half of each result.
- The host side of this block is the other end of the load/compute/finish/read handshake used by mm_top.

Parameters:
- SLOTS, 32, number of result slots.
- SLOT_AW, 5, slot address width; must equal clog2(SLOTS).
- RESULTS, 16, results per slot (4x4 product).
- RES_W, 18, stored result width.
- OUT_W, 9, output bus width; must equal RES_W/2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset), release is synchronous to clk.
- res_we  in  1  core write strobe for one result.
- res_slot  in  SLOT_AW  core write slot.
- res_idx  in  4  core write entry index, 0..15, row-major.
- res_data  in  RES_W  result value.
- read  in  1  host read request, sampled on the rising edge.
- ram_slot  in  SLOT_AW  slot to read, sampled together with read.
- out_data  out  OUT_W  serialized result half.
- out_valid  out  1  high while out_data carries a beat.
- busy  out  1  high while streaming.

Behaviour:
- Reset (rst=0), applied at any time including mid-stream:
  - out_data=0, out_valid=0, busy=0.
  - State forced to IDLE and beat counter cleared; any stream in progress is abandoned.
  - Storage is not cleared, unless the optional feature below is compiled in.
- Storage: SLOTS x RESULTS x RES_W array.
  - On a rising edge with res_we=1, mem[res_slot][res_idx] <= res_data.
  - Writes are accepted in every state, including while streaming.
- FSM has two states, IDLE and STREAM.
- IDLE:
  - read=1 at edge E0 latches ram_slot into cur_slot, clears beat to 0 and enters STREAM.
  - At E0 the block also registers beat 0: out_data = mem[ram_slot][0][8:0] and out_valid=1.
- STREAM:
  - At each edge E(k+1), beat k+1 is registered.
  - Beat b uses entry b>>1; b[0]=0 selects bits [8:0], b[0]=1 selects bits [17:9].
  - out_data therefore holds beat k during the cycle after edge E(k).
  - Beat 31 (entry 15, high half) is held for the cycle after E31.
  - At E32: out_data=0, out_valid=0, busy=0, state returns to IDLE.
- Timing summary: 32 beats, first beat visible one edge after the request; busy is high from E0 through E32.
- read while busy is ignored; cur_slot does not change.
  - The earliest new request is sampled at E32, which both ends the current stream and starts the next one.
  - In that case out_valid stays 1 and out_data shows beat 0 of the new slot.
- Read/write collision: a write at the same edge that reads the same entry is not visible to that beat; the beat shows the old value.
  - Later beats of the same entry (e.g. the high half after the low half) show the new value.
- Beat counter is 5 bits and stops at 31; it never wraps within a stream.

Optional Feature:
- Macro: MM_RESULT_CLEAR_EN.
- Defined: every storage entry is forced to 0 on reset, so reading a never-written slot returns 32 beats of 0.
- Undefined: storage has no reset (RAM-inferable) and unwritten entries read as don't-care.
- Port list, latency and all other behaviour are identical in both builds.

Test Plan:
- Write slot 3, entries i=0..15 with value 0x20000+i (high=0x100, low=i); pulse read with ram_slot=3 → 32 beats: 0x000,0x100,0x001,0x100,...,0x00F,0x100; out_valid high for exactly 32 cycles; busy drops at E32.
- Write slot 31, entry 15 = 0x3FFFF; read slot 31 → beats 30/31 = 0x1FF/0x1FF; upper slot bound has no aliasing with slot 0.
- Stream slot 0 while asserting read with ram_slot=5 at beats 4..20 → stream stays on slot 0; a request exactly at E32 starts slot 5 with out_valid continuously high.
- Stream slot 2 and, at the edge that registers beat 6, write entry 3 = 0x00155 → beat 6 shows the old low half, beat 7 shows 0x000 (new high half).
- Drop rst to 0 at beat 10 → out_data=0, out_valid=0, busy=0 asynchronously; after release, a read of the same slot restarts at beat 0.
- With MM_RESULT_CLEAR_EN: reset, then read unwritten slot 7 → 32 beats of 0x000.
